// File: rtl/fa_bist_checker_pkg.sv
// Shared types and constants for the full-adder BIST checker.
// Optional first-failure logging is enabled by defining FA_BIST_LOG_EN.
package fa_bist_checker_pkg;

  localparam int FA_VEC_W = 3;
  localparam int FA_ERR_W = 4;
  localparam logic [FA_VEC_W-1:0] FA_LAST_VEC = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } fa_state_t;

endpackage

// File: rtl/fa_golden.sv
// Reference full adder: the expected sum/carry for one stimulus vector.
module fa_golden (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ c;
  assign co = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/fa_bist_checker.sv
// Exhaustive BIST for an external full adder: walks vectors 000..111 and counts mismatches.
// Define FA_BIST_LOG_EN to add fail_vec/fail_seen capture of the first failing vector.
module fa_bist_checker
  import fa_bist_checker_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                a_o,
  output logic                b_o,
  output logic                c_o,
  input  logic                s_i,
  input  logic                co_i,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [FA_ERR_W-1:0] err_cnt,
  output logic [1:0]          dbg_state
`ifdef FA_BIST_LOG_EN
  ,
  output logic [FA_VEC_W-1:0] fail_vec,
  output logic                fail_seen
`endif
);

  // Handshake: start is sampled only in IDLE or DONE (ignored while busy=1);
  // busy is high in APPLY/CHECK; done/pass/err_cnt hold until the next start or rst.

  fa_state_t             state_q, state_d;
  logic [FA_VEC_W-1:0]   vec_q;
  logic [FA_ERR_W-1:0]   err_q;
  logic                  run_load;
  logic                  vec_inc;
  logic                  do_check;
  logic                  gold_s;
  logic                  gold_co;
  logic                  mismatch;

  fa_golden u_golden (
    .a  (vec_q[2]),
    .b  (vec_q[1]),
    .c  (vec_q[0]),
    .s  (gold_s),
    .co (gold_co)
  );

  assign mismatch = (s_i != gold_s) || (co_i != gold_co);

  always_comb begin
    state_d  = state_q;
    run_load = 1'b0;
    vec_inc  = 1'b0;
    do_check = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = APPLY;
          run_load = 1'b1;
        end
      end
      APPLY: state_d = CHECK;
      CHECK: begin
        do_check = 1'b1;
        if (vec_q == FA_LAST_VEC) begin
          state_d = DONE;
        end else begin
          state_d = APPLY;
          vec_inc = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vec_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      if (run_load) begin
        vec_q <= '0;
        err_q <= '0;
      end else begin
        if (vec_inc) vec_q <= vec_q + FA_VEC_W'(1);
        if (do_check && mismatch) err_q <= err_q + FA_ERR_W'(1);
      end
    end
  end

`ifdef FA_BIST_LOG_EN
  // Only the first failure of a run is kept; later ones leave the capture alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      fail_vec  <= '0;
      fail_seen <= 1'b0;
    end else if (run_load) begin
      fail_vec  <= '0;
      fail_seen <= 1'b0;
    end else if (do_check && mismatch && !fail_seen) begin
      fail_vec  <= vec_q;
      fail_seen <= 1'b1;
    end
  end
`endif

  assign a_o       = vec_q[2];
  assign b_o       = vec_q[1];
  assign c_o       = vec_q[0];
  assign busy      = (state_q == APPLY) || (state_q == CHECK);
  assign done      = (state_q == DONE);
  assign pass      = done && (err_q == '0);
  assign err_cnt   = err_q;
  assign dbg_state = state_q;

endmodule

// File: doc/fa_bist_checker.md
FA_BIST_CHECKER -- requirements
Module: fa_bist_checker

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Ports SHALL be `clk`, input, 1 bit: the single rising-edge clock.
REQ-003 Ports SHALL include `rst`, input, 1 bit: synchronous, active-high reset.
REQ-004 Ports SHALL include `start`, input, 1 bit: begin an exhaustive full-adder test (pulse or level).
REQ-005 Ports SHALL include `a_o`, `b_o` and `c_o`, each an output of 1 bit: the stimulus vector driven to the external full adder's Ain/Bin/Cin.
REQ-006 Ports SHALL include `s_i` and `co_i`, each an input of 1 bit: the Sout/Cout response from the external full adder.
REQ-007 Ports SHALL include `busy`, output, 1 bit: test in progress.
REQ-008 Ports SHALL include `done`, output, 1 bit: test complete, held until the next start or reset.
REQ-009 Ports SHALL include `pass`, output, 1 bit: valid while `done`=1; 1 means zero mismatches.
REQ-010 Ports SHALL include `err_cnt`, output, 4 bits: number of failing vectors, range 0..8.

Function
REQ-011 FSM states SHALL be IDLE, APPLY, CHECK and DONE.
REQ-012 A 3-bit vector register `vec` SHALL drive the stimulus outputs:
  - `a_o` = `vec[2]`, `b_o` = `vec[1]`, `c_o` = `vec[0]`.
  - Sequence SHALL be 000 to 111 in ascending order.
REQ-013 IDLE or DONE with `start`=1 SHALL take the FSM to APPLY with `vec`=0 and `err_cnt`=0; `done` and `pass` SHALL clear on that edge.
REQ-014 Each vector SHALL be held for exactly two cycles: one APPLY cycle, then one CHECK cycle.
REQ-015 On the clock edge leaving CHECK, the block SHALL compare `s_i`/`co_i` against golden values computed from `vec`:
  - golden sum = a^b^c;
  - golden carry = majority(a,b,c).
REQ-016 A vector SHALL count as failing if either bit mismatches; `err_cnt` SHALL increment by exactly 1 per failing vector, with no saturation needed (maximum 8).
REQ-017 CHECK with `vec`=7 SHALL go to DONE; otherwise CHECK SHALL go to APPLY with `vec`+1. `vec` SHALL never wrap during a run.
REQ-018 Total latency from the `start` edge to `done`=1 SHALL be 16 cycles.
REQ-019 `busy` SHALL be 1 exactly in APPLY and CHECK.
REQ-020 `pass` SHALL be 1 only in DONE with `err_cnt`=0.
REQ-021 `start` SHALL be ignored while `busy`=1.
REQ-022 DONE SHALL persist, with results stable, until `start` or `rst`.
REQ-023 `start` held high in DONE SHALL restart immediately; back-to-back runs are legal.

Reset
REQ-024 `rst`=1 at a clock edge SHALL force all of the following, with priority over `start`, including mid-run:
  - state = IDLE and `vec` = 0;
  - `a_o`, `b_o`, `c_o`, `busy`, `done`, `pass` = 0;
  - `err_cnt` = 0.
REQ-025 No partial result SHALL survive a reset.

Configuration
REQ-026 Macro `FA_BIST_LOG_EN`, when defined, SHALL add output `fail_vec` (3 bits) and output `fail_seen` (1 bit):
  - they capture the first failing `vec` of the run;
  - both reset to 0 and clear on `start`;
  - later failures SHALL NOT overwrite the capture.
REQ-027 With the macro undefined, those ports and their registers SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-028 A shared package SHALL hold:
  - the FSM state enum;
  - `FA_VEC_W` = 3;
  - `FA_LAST_VEC` = 7;
  - `FA_ERR_W` = 4.
REQ-029 The golden model SHALL be one combinational sub-module, `fa_golden` (inputs a, b, c; outputs s, co), instantiated once.

Verification
REQ-030 Correct full adder attached, `start` pulsed -> `busy` for 16 cycles, then `done`=1, `pass`=1, `err_cnt`=0.
REQ-031 Adder with `co` stuck-at-0 -> `err_cnt`=4 (vectors 3, 5, 6, 7), `pass`=0; with the macro, `fail_vec`=3 and `fail_seen`=1.
REQ-032 Adder with inverted sum -> `err_cnt`=8, `pass`=0; with the macro, `fail_vec`=0.
REQ-033 `start` re-pulsed at cycle 5 of a run -> ignored; `done` still at cycle 16 and the result is unchanged.
REQ-034 `rst` asserted at cycle 9 of a run -> the next cycle shows IDLE, all outputs 0; a fresh `start` then completes normally with `pass`=1.
REQ-035 `start` held high continuously with the correct adder -> repeated 16-cycle runs with a one-cycle DONE between runs, each run reporting `pass`=1.
